// File: rtl/custom_fifo_pkg.sv
// Shared types and constants for the custom async FIFO read-side blocks.
// The optional statistics counters are built only when CUSTOM_RD_STATS_EN is defined.
package custom_fifo_pkg;

  localparam int DATASIZE_C   = 8;
  // The skid buffer is fixed at two entries: one output register plus one skid slot.
  localparam int SKID_DEPTH_C = 2;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_STREAM = 2'd1,
    RD_FLUSH  = 2'd2
  } rd_state_e;

  typedef logic [15:0] stat_cnt_t;

  // Saturating increment for the 16-bit statistics counters.
  function automatic stat_cnt_t stat_sat_inc(input stat_cnt_t v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/custom_skid_buf.sv
// Two-entry in-order buffer. Entry 0 (head) drives the stream output; entry 1
// is the skid slot that absorbs a word landing while the head is stalled.
module custom_skid_buf #(
  parameter int DATASIZE = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                clr_i,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [DATASIZE-1:0] din_i,
  output logic [1:0]          occ_o,
  output logic [DATASIZE-1:0] head_o
);

  logic [DATASIZE-1:0] head_q, head_d;
  logic [DATASIZE-1:0] tail_q, tail_d;
  logic [1:0]          occ_q, occ_d;

  // Next-state: clear wins; push into the first free slot; pop promotes the skid entry.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (clr_i) begin
      occ_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_d = din_i;
            occ_d  = 2'd1;
          end else begin
            tail_d = din_i;
            occ_d  = 2'd2;
          end
        end
        2'b01: begin
          if (occ_q == 2'd2) head_d = tail_q;
          occ_d = occ_q - 2'd1;
        end
        2'b11: begin
          // Capture and pop together: occupancy is unchanged, order preserved.
          if (occ_q == 2'd2) begin
            head_d = tail_q;
            tail_d = din_i;
          end else begin
            head_d = din_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage registers, cleared immediately by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = head_q;

endmodule

// File: rtl/custom_fifo_rd_stream.sv
// Read-side consumer of the custom async FIFO: issues reads, absorbs the
// one-cycle read latency in a skid buffer and presents a valid/ready stream.
// Define CUSTOM_RD_STATS_EN to add the rd_word_cnt / rd_stall_cnt outputs.
module custom_fifo_rd_stream
  import custom_fifo_pkg::*;
#(
  parameter int DATASIZE   = DATASIZE_C,
  parameter int SKID_DEPTH = SKID_DEPTH_C
) (
  input  logic                rclk_i,
  input  logic                rrst_n_i,
  input  logic                fifo_empty,
  input  logic [DATASIZE-1:0] fifo_dout,
  output logic                fifo_ren,
  output logic                m_valid,
  output logic [DATASIZE-1:0] m_data,
  input  logic                m_ready,
  input  logic                flush_i,
  output logic                flush_busy
`ifdef CUSTOM_RD_STATS_EN
 ,output logic [15:0]         rd_word_cnt
 ,output logic [15:0]         rd_stall_cnt
`endif
);

  // Only a depth of 2 is supported; it bounds occupancy plus in-flight words.
  localparam logic [1:0] OCC_MAX = 2'(SKID_DEPTH);

  rd_state_e           state_q;
  logic                flush_busy_q;
  logic                inflight_q, inflight_d;
  logic                ren_en_q;
  logic [1:0]          occ;
  logic [DATASIZE-1:0] head;
  logic                pop;
  logic                flush_take;
  logic [1:0]          level;
  logic [1:0]          level_nxt;
  logic                sb_push, sb_pop;

  assign m_valid    = (occ != 2'd0);
  assign m_data     = head;
  assign flush_busy = flush_busy_q;
  assign pop        = m_valid & m_ready;

  // A flush request arriving while already flushing is ignored.
  assign flush_take = flush_i & (state_q != RD_FLUSH);

  // Words held after this cycle if no new read is issued; never exceeds 2.
  assign level     = occ + {1'b0, inflight_q} - {1'b0, pop};
  assign level_nxt = level + {1'b0, fifo_ren};

  // ren_en_q keeps the read enable low during reset and the first cycle after it.
  assign fifo_ren = ren_en_q & ~fifo_empty & ~flush_i
                  & ((state_q == RD_STREAM) | (state_q == RD_IDLE))
                  & (level < OCC_MAX);

  // A landing word is dropped when a flush is taken or already in progress.
  assign sb_push = inflight_q & (state_q != RD_FLUSH) & ~flush_take;
  assign sb_pop  = pop & ~flush_take;

  custom_skid_buf #(
    .DATASIZE (DATASIZE)
  ) u_skid (
    .clk_i   (rclk_i),
    .rst_n_i (rrst_n_i),
    .clr_i   (flush_take),
    .push_i  (sb_push),
    .pop_i   (sb_pop),
    .din_i   (fifo_dout),
    .occ_o   (occ),
    .head_o  (head)
  );

  // In-flight tracking: on a taken flush the flag is held for one cycle to
  // account for the discarded landing word, then cleared during RD_FLUSH.
  always_comb begin
    inflight_d = fifo_ren;
    if (flush_take)                inflight_d = inflight_q;
    else if (state_q == RD_FLUSH)  inflight_d = 1'b0;
  end

  // Control registers: in-flight flag and post-reset read enable.
  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      inflight_q <= 1'b0;
      ren_en_q   <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      ren_en_q   <= 1'b1;
    end
  end

  // Read FSM with registered flush_busy output.
  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      state_q      <= RD_IDLE;
      flush_busy_q <= 1'b0;
    end else begin
      case (state_q)
        RD_IDLE: begin
          if (flush_take) begin
            state_q      <= RD_FLUSH;
            flush_busy_q <= 1'b1;
          end else if (fifo_ren) begin
            state_q <= RD_STREAM;
          end
        end
        RD_STREAM: begin
          if (flush_take) begin
            state_q      <= RD_FLUSH;
            flush_busy_q <= 1'b1;
          end else if (level_nxt == 2'd0) begin
            state_q <= RD_IDLE;
          end
        end
        RD_FLUSH: begin
          if (!inflight_q) begin
            state_q      <= RD_IDLE;
            flush_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= RD_IDLE;
          flush_busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CUSTOM_RD_STATS_EN
  stat_cnt_t word_cnt_q, stall_cnt_q;

  // Saturating pop and stall counters, cleared by any flush request.
  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else if (flush_i) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop)                 word_cnt_q  <= stat_sat_inc(word_cnt_q);
      if (m_valid && !m_ready) stall_cnt_q <= stat_sat_inc(stall_cnt_q);
    end
  end

  assign rd_word_cnt  = word_cnt_q;
  assign rd_stall_cnt = stall_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_custom_fifo_rd_stream.sv
// Scoreboard bench for custom_fifo_rd_stream: a queue-based FIFO model feeds
// the DUT, every accepted read is pushed to the expected queue and every
// stream handshake pops and compares it.
module tb_custom_fifo_rd_stream;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_ren;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic          flush_i = 1'b0;
  logic          flush_busy;
`ifdef CUSTOM_RD_STATS_EN
  logic [15:0]   rd_word_cnt;
  logic [15:0]   rd_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pop_log[$];
  int            pop_cyc[$];
  int            cyc = 0, rd_cnt = 0, pop_cnt = 0, stall_cnt = 0;
  int            max_lvl = 0, bad_ren = 0;
  logic          rd_go = 1'b0;

  custom_fifo_rd_stream #(.DATASIZE(DW), .SKID_DEPTH(2)) dut (
    .rclk_i     (clk),
    .rrst_n_i   (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_ren   (fifo_ren),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .flush_i    (flush_i),
    .flush_busy (flush_busy)
`ifdef CUSTOM_RD_STATS_EN
   ,.rd_word_cnt  (rd_word_cnt)
   ,.rd_stall_cnt (rd_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor at the falling edge: handshakes, flush discards and read acceptance.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (fifo_ren && fifo_empty) bad_ren++;
      if (exp_q.size() > max_lvl) max_lvl = exp_q.size();
      if (m_valid && m_ready) begin
        pop_cnt++;
        pop_cyc.push_back(cyc);
        pop_log.push_back(m_data);
        if (exp_q.size() == 0) chk("pop_unexpected", 32'(m_data), 32'hFFFF_FFFF);
        else                   chk("pop_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      if (m_valid && !m_ready) stall_cnt++;
      if (flush_i) exp_q.delete();
      rd_go = fifo_ren && !fifo_empty;
      if (rd_go) rd_cnt++;
    end else begin
      rd_go = 1'b0;
    end
  end

  // FIFO model: read data appears one cycle after the accepting edge.
  always @(posedge clk) begin
    #1;
    if (rd_go && fifo_q.size() > 0) begin
      fifo_dout = fifo_q.pop_front();
      exp_q.push_back(fifo_dout);
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_words(input int n, input int base);
    for (int i = 0; i < n; i++) fifo_q.push_back(8'(base + i));
    fifo_empty = 1'b0;
  endtask

  task automatic wait_pops(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (pop_cnt < target && n < budget) begin
      step();
      n++;
    end
    if (pop_cnt < target) chk(tag, 32'(pop_cnt), 32'(target));
  endtask

  task automatic count_busy(output int nb);
    nb = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (flush_busy) nb++;
    end
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ren_h[10], vld_h[10];
    int fr, lr, fv, lv, nr, nv, pc0, rc0, maxgap, hold_bad, kreads, nb;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ren",   32'(fifo_ren),   32'd0);
    chk("rst_valid", 32'(m_valid),    32'd0);
    chk("rst_data",  32'(m_data),     32'd0);
    chk("rst_busy",  32'(flush_busy), 32'd0);
    #21 rst_n = 1'b1;
    repeat (3) step();

    // Four words A..D with m_ready high
    m_ready = 1'b1;
    pc0 = pop_cnt;
    push_words(4, 8'hA0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ren_h[c] = int'(fifo_ren);
      vld_h[c] = int'(m_valid);
    end
    step();
    fr = -1; lr = -1; fv = -1; lv = -1; nr = 0; nv = 0;
    for (int c = 0; c < 10; c++) begin
      if (ren_h[c] != 0) begin if (fr < 0) fr = c; lr = c; nr++; end
      if (vld_h[c] != 0) begin if (fv < 0) fv = c; lv = c; nv++; end
    end
    chk("t1_ren_cnt", 32'(nr), 32'd4);
    chk("t1_ren_run", 32'(lr - fr + 1), 32'd4);
    chk("t1_latency", 32'(fv - fr), 32'd2);
    chk("t1_vld_run", 32'(lv - fv + 1), 32'd4);
    chk("t1_pops", 32'(pop_cnt - pc0), 32'd4);
    chk("t1_idle", 32'({m_valid, fifo_ren}), 32'd0);

    // Five words under backpressure
    m_ready = 1'b0;
    rc0 = rd_cnt;
    push_words(5, 8'h50);
    hold_bad = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (m_valid && m_data !== 8'h50) hold_bad++;
    end
    @(negedge clk);
    chk("t2_reads", 32'(rd_cnt - rc0), 32'd2);
    chk("t2_ren_off", 32'(fifo_ren), 32'd0);
    chk("t2_valid", 32'(m_valid), 32'd1);
    chk("t2_hold", 32'(m_data), 32'h50);
    chk("t2_hold_stable", 32'(hold_bad), 32'd0);
    step();
    pop_cyc.delete();
    pc0 = pop_cnt;
    m_ready = 1'b1;
    wait_pops(pc0 + 5, 40, "t2_drain_timeout");
    maxgap = 0;
    for (int i = 1; i < pop_cyc.size(); i++)
      if (pop_cyc[i] - pop_cyc[i-1] > maxgap) maxgap = pop_cyc[i] - pop_cyc[i-1];
    chk("t2_gap", 32'(maxgap <= 2), 32'd1);
    chk("t2_pops", 32'(pop_cnt - pc0), 32'd5);

    // 64 words with m_ready toggling
    repeat (3) step();
    max_lvl = 0;
    pc0 = pop_cnt;
    push_words(64, 8'h00);
    for (int i = 0; i < 400 && pop_cnt < pc0 + 64; i++) begin
      m_ready = ~m_ready;
      step();
    end
    m_ready = 1'b1;
    repeat (4) step();
    chk("t3_pops", 32'(pop_cnt - pc0), 32'd64);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t3_max_level", 32'(max_lvl <= 2), 32'd1);

    // Flush mid-stream
    rc0 = rd_cnt;
    pc0 = pop_cnt;
    push_words(8, 8'h80);
    wait_pops(pc0 + 2, 20, "t4_start_timeout");
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    kreads = rd_cnt - rc0;
    pop_log.delete();
    @(negedge clk);
    chk("t4_valid_drop", 32'(m_valid), 32'd0);
    nb = int'(flush_busy);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (flush_busy) nb++;
    end
    step();
    chk("t4_busy_cycles", 32'(nb), 32'd2);
    for (int i = 0; i < 40 && (fifo_q.size() != 0 || exp_q.size() != 0); i++) step();
    repeat (2) step();
    chk("t4_log_nonempty", 32'(pop_log.size() > 0), 32'd1);
    if (pop_log.size() > 0) chk("t4_next_word", 32'(pop_log[0]), 32'(8'h80 + kreads));
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Flush while idle: single-cycle busy pulse
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    count_busy(nb);
    chk("t4_idle_busy", 32'(nb + 1), 32'd2);

    // Asynchronous reset mid-burst
    pc0 = pop_cnt;
    push_words(10, 8'hC0);
    wait_pops(pc0 + 3, 20, "t5_start_timeout");
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_ren",   32'(fifo_ren),   32'd0);
    chk("t5_rst_valid", 32'(m_valid),    32'd0);
    chk("t5_rst_data",  32'(m_data),     32'd0);
    chk("t5_rst_busy",  32'(flush_busy), 32'd0);
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    repeat (3) step();
    #2 rst_n = 1'b1;
    pc0 = pop_cnt;
    repeat (4) step();
    chk("t5_no_stale", 32'({m_valid, 8'(pop_cnt - pc0)}), 32'd0);
    push_words(3, 8'h70);
    wait_pops(pc0 + 3, 20, "t5_resume_timeout");
    repeat (2) step();
    chk("t5_resume", 32'(pop_cnt - pc0), 32'd3);

`ifdef CUSTOM_RD_STATS_EN
    // Statistics: 10 pops with 3 stall cycles
    m_ready = 1'b0;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    repeat (3) step();
    pc0 = pop_cnt;
    push_words(10, 8'hE0);
    for (int i = 0; i < 20 && !m_valid; i++) step();
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    m_ready = 1'b1;
    wait_pops(pc0 + 10, 40, "t6_timeout");
    repeat (2) step();
    chk("t6_word_cnt",  32'(rd_word_cnt),  32'd10);
    chk("t6_stall_cnt", 32'(rd_stall_cnt), 32'd3);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    repeat (3) step();
    chk("t6_word_clr",  32'(rd_word_cnt),  32'd0);
    chk("t6_stall_clr", 32'(rd_stall_cnt), 32'd0);
`endif

    chk("no_ren_when_empty", 32'(bad_ren), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
